// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, with a valid/ready handshake on both the operand side and the result side.
// Produces the result plus carry/borrow, overflow, zero and negative flags.
module serial_addsub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z,
  output logic             flag_n
);

  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d, sub_q, sub_d;
  logic               a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic               flag_c_q, flag_c_d, flag_v_q, flag_v_d;
  logic               flag_z_q, flag_z_d, flag_n_q, flag_n_d;
  logic               in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic [DIGIT:0]     dsum_c;
  logic [WIDTH-1:0]   acc_next_c;

  // One digit of the ripple: low digits of both operands plus running carry.
  assign dsum_c     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
  // Sum digits enter at the top so the first digit ends up in the LSBs.
  assign acc_next_c = WIDTH'({dsum_c[DIGIT-1:0], acc_q} >> DIGIT);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    result_d = result_q;
    flag_c_d = flag_c_q;
    flag_v_d = flag_v_q;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = op[0] ? ~b : b;
          sub_d   = op[0];
          carry_d = op[1] ? (cin ^ op[0]) : op[0];
          a_msb_d = a[WIDTH-1];
          b_msb_d = op[0] ? ~b[WIDTH-1] : b[WIDTH-1];
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dsum_c[DIGIT];
        acc_d   = acc_next_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          state_d  = DONE;
          result_d = acc_next_c;
          flag_c_d = dsum_c[DIGIT] ^ sub_q;
          flag_v_d = (a_msb_q == b_msb_q) && (acc_next_c[WIDTH-1] != a_msb_q);
          flag_z_d = (acc_next_c == '0);
          flag_n_d = acc_next_c[WIDTH-1];
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      result_q    <= '0;
      flag_c_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_n_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      result_q    <= result_d;
      flag_c_q    <= flag_c_d;
      flag_v_q    <= flag_v_d;
      flag_z_q    <= flag_z_d;
      flag_n_q    <= flag_n_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag_c    = flag_c_q;
  assign flag_v    = flag_v_q;
  assign flag_z    = flag_z_q;
  assign flag_n    = flag_n_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: a bit-serial (DIGIT=1) and a nibble-serial (DIGIT=4) instance share stimulus.
// Each result is compared with an arithmetic reference model.
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, out_ready, cin;
  logic [1:0] op;
  logic [7:0] a, b;

  logic       in_ready0, out_valid0, c0, v0, z0, n0;
  logic [7:0] res0;
  logic       in_ready1, out_valid1, c1, v1, z1, n1;
  logic [7:0] res1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut_d1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .op(op),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid0), .out_ready(out_ready),
    .result(res0), .flag_c(c0), .flag_v(v0), .flag_z(z0), .flag_n(n0));

  serial_addsub #(.WIDTH(8), .DIGIT(4)) u_dut_d4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1), .op(op),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid1), .out_ready(out_ready),
    .result(res1), .flag_c(c1), .flag_v(v1), .flag_z(z1), .flag_n(n1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; c is carry for add, borrow for subtract.
  function automatic void model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                                input logic ci, output logic [7:0] r, output logic c, output logic v);
    int s;
    int bin;
    bin = o[1] ? int'(ci) : 0;
    if (!o[0]) begin
      s = int'(x) + int'(y) + bin;
      c = (s > 255);
      r = s[7:0];
      v = (x[7] == y[7]) && (r[7] != x[7]);
    end else begin
      s = int'(x) - int'(y) - bin;
      c = (s < 0);
      r = s[7:0];
      v = (x[7] != y[7]) && (r[7] != x[7]);
    end
  endfunction

  task automatic do_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic ci, input int hold);
    logic [7:0] er, prev0;
    logic       ec, ev;
    int         lat0, lat1;
    model(o, x, y, ci, er, ec, ev);
    prev0 = res0;
    op = o; a = x; b = y; cin = ci; in_valid = 1'b1;
    check("in_ready_idle", 32'(in_ready0), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 2'($urandom); a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    check("in_ready_run", 32'(in_ready0), 32'd0);
    lat0 = 0; lat1 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_valid1 && lat1 == 0) lat1 = k;
      if (out_valid0) begin
        lat0 = k;
        break;
      end
      if (k == 3) check("result_hold_run", 32'(res0), 32'(prev0));
    end
    check("latency_d1", lat0, 8);
    check("latency_d4", lat1, 2);
    check("result_d1", 32'(res0), 32'(er));
    check("flag_c_d1", 32'(c0), 32'(ec));
    check("flag_v_d1", 32'(v0), 32'(ev));
    check("flag_z_d1", 32'(z0), 32'(er == 8'h00));
    check("flag_n_d1", 32'(n0), 32'(er[7]));
    check("result_d4", 32'(res1), 32'(er));
    check("flag_c_d4", 32'(c1), 32'(ec));
    check("flag_v_d4", 32'(v1), 32'(ev));
    check("flag_z_d4", 32'(z1), 32'(er == 8'h00));
    check("flag_n_d4", 32'(n1), 32'(er[7]));
    in_valid = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_result", 32'(res0), 32'(er));
      check("hold_flags", {28'd0, c0, v0, z0, n0}, {28'd0, ec, ev, er == 8'h00, er[7]});
      check("hold_valid", 32'(out_valid0), 32'd1);
      check("hold_in_ready", 32'(in_ready0), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid_d1", 32'(out_valid0), 32'd0);
    check("release_ready_d1", 32'(in_ready0), 32'd1);
    check("release_valid_d4", 32'(out_valid1), 32'd0);
    check("release_ready_d4", 32'(in_ready1), 32'd1);
  endtask

  initial begin
    int seen;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check("rst_in_ready", 32'(in_ready0), 32'd1);
    check("rst_out_valid", 32'(out_valid0), 32'd0);
    check("rst_result", 32'(res0), 32'd0);
    check("rst_flags", {28'd0, c0, v0, z0, n0}, 32'd0);

    do_op(2'b00, 8'h7F, 8'h01, 1'b0, 0);
    do_op(2'b01, 8'h00, 8'h01, 1'b0, 5);
    do_op(2'b11, 8'h05, 8'h05, 1'b1, 0);
    do_op(2'b10, 8'hFF, 8'h00, 1'b1, 2);
    do_op(2'b00, 8'h0F, 8'h01, 1'b0, 0);
    do_op(2'b01, 8'h80, 8'h01, 1'b0, 0);
    do_op(2'b10, 8'h7F, 8'h00, 1'b1, 0);

    for (int i = 0; i < 40; i++)
      do_op(2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    // Abort an operation mid-flight with reset.
    op = 2'b00; a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    check("abort_in_ready", 32'(in_ready0), 32'd1);
    check("abort_out_valid", 32'(out_valid0), 32'd0);
    check("abort_result", 32'(res0), 32'd0);
    check("abort_flags", {28'd0, c0, v0, z0, n0}, 32'd0);
    check("abort_result_d4", 32'(res1), 32'd0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid0 || out_valid1) seen++;
    end
    check("abort_no_output", seen, 0);

    do_op(2'b01, 8'h40, 8'hC0, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits; legal range WIDTH >= 2.
REQ-002 SHALL have parameter DIGIT, default 1: bits processed per cycle; legal only where DIGIT divides WIDTH; STEPS = WIDTH/DIGIT.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: operands and op presented.
REQ-006 SHALL have port in_ready, output, 1: block can accept operands.
REQ-007 SHALL have port op, input, 2: 00 ADD, 01 SUB, 10 ADC (add with carry), 11 SBB (subtract with borrow).
REQ-008 SHALL have port a, input, WIDTH: first operand.
REQ-009 SHALL have port b, input, WIDTH: second operand.
REQ-010 SHALL have port cin, input, 1: carry-in for ADC and borrow-in for SBB; ignored for ADD/SUB.
REQ-011 SHALL have port out_valid, output, 1: result and flags valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have port result, output, WIDTH: a op b, modulo 2^WIDTH.
REQ-014 SHALL have port flag_c, output, 1: carry-out for ADD/ADC; borrow-out for SUB/SBB.
REQ-015 SHALL have port flag_v, output, 1: two's-complement signed overflow.
REQ-016 SHALL have port flag_z, output, 1: result == 0.
REQ-017 SHALL have port flag_n, output, 1: result[WIDTH-1].

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE.
REQ-019 SHALL assert in_ready only in IDLE and out_valid only in DONE.
REQ-020 SHALL accept on the rising edge where in_valid and in_ready are both 1, latching a, op, cin and b (b bitwise inverted for SUB/SBB), then move to RUN with step count 0.
REQ-021 SHALL set initial carry to 0 for ADD, 1 for SUB, cin for ADC, and ~cin for SBB.
REQ-022 SHALL, in each RUN cycle, add the DIGIT least-significant unprocessed bits of both operands plus the running carry, shift the DIGIT sum bits into the result register LSB-first, and register the carry.
REQ-023 SHALL move to DONE on the edge that completes step STEPS-1, so out_valid rises exactly STEPS cycles after the accepting edge.
REQ-024 SHALL compute flag_c as the final carry for ADD/ADC and its inverse for SUB/SBB.
REQ-025 SHALL compute flag_v = (a_msb == b'_msb) and (result_msb != a_msb), where b' is the post-inversion operand.
REQ-026 SHALL hold result and all flags stable in DONE until out_ready is 1, then return to IDLE on that edge.
REQ-027 SHALL ignore in_valid in RUN and DONE; a new operation is accepted no earlier than the cycle after the result handshake, giving a minimum issue interval of STEPS+2 cycles.
REQ-028 SHALL leave result and flags holding the last completed values while in IDLE and RUN; they are only updated on the RUN-to-DONE edge.
REQ-029 SHALL ignore op and operand changes after acceptance.

Reset
REQ-030 SHALL, when reset is 0 at a rising edge, go to IDLE and clear result, all flags, the step counter, the carry and the operand registers to 0.
REQ-031 SHALL give in_ready = 1 and out_valid = 0 on the cycle after reset.
REQ-032 SHALL discard any operation in RUN or DONE when reset is applied, producing no out_valid.
REQ-033 SHALL give reset priority over any simultaneous in_valid or out_ready handshake.

Verification
REQ-034 SHALL pass: WIDTH=8, DIGIT=1, ADD 0x7F+0x01 -> out_valid 8 cycles after accept, result 0x80, c=0, v=1, n=1, z=0.
REQ-035 SHALL pass: SUB 0x00-0x01 -> result 0xFF, c=1, v=0, n=1, z=0; SBB 0x05-0x05 with cin=1 -> result 0xFF, c=1.
REQ-036 SHALL pass: ADC 0xFF+0x00 with cin=1 -> result 0x00, c=1, z=1, v=0.
REQ-037 SHALL pass: out_ready held 0 for 5 cycles in DONE with in_valid=1 -> result and flags unchanged, in_ready=0, no new accept; out_ready=1 -> IDLE next cycle.
REQ-038 SHALL pass: reset=0 during RUN step 3 -> next cycle in_ready=1, out_valid=0, result=0, and no result is ever presented for that operation.
REQ-039 SHALL pass: WIDTH=8, DIGIT=4, ADD 0x0F+0x01 -> out_valid 2 cycles after accept, result 0x10, c=0.
